// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM encodings, counter
// width and the NOP word the pipeline registers load on a flush.
package pc_ctrl_pkg;

    typedef enum logic {
        CTRL_RUN  = 1'b0,
        CTRL_HOLD = 1'b1
    } ctrl_state_e;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pc_ctrl.sv
// Pipeline control: owns the PC, turns execute-stage jump/hold requests into
// fetch redirects, pipeline stalls and pipeline flushes.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              jump_en_i_exu2ctrl,
    input  logic [31:0]       jump_to_addr_i_exu2ctrl,
    input  logic              hold_flag_i_exu2ctrl,
    output logic [ADDR_W-1:0] pc_o_ctrl_ifu,
    output logic              hold_o_ctrl_pipe,
    output logic              flush_o_ctrl_pipe,
    output logic              misalign_o
);

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              hold_q, hold_d;
    logic              mis_q, mis_d;
    logic              hold_rise;
    logic              unused_tgt_bits;

    // Target bits above ADDR_W are intentionally dropped.
    assign unused_tgt_bits = ^jump_to_addr_i_exu2ctrl;

    assign hold_rise = hold_flag_i_exu2ctrl & ~hold_q;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        pc_d              = pc_q;
        hold_d            = hold_q;
        mis_d             = mis_q;
        hold_o_ctrl_pipe  = 1'b0;
        flush_o_ctrl_pipe = 1'b0;

        if (!en_i) begin
            hold_o_ctrl_pipe = 1'b1;
        end else begin
            hold_d = hold_flag_i_exu2ctrl;
            if (jump_en_i_exu2ctrl) begin
                flush_o_ctrl_pipe = 1'b1;
                pc_d    = {jump_to_addr_i_exu2ctrl[ADDR_W-1:2], 2'b00};
                state_d = CTRL_RUN;
                cnt_d   = '0;
                if (jump_to_addr_i_exu2ctrl[1:0] != 2'b00)
                    mis_d = 1'b1;
            end else if (state_q == CTRL_HOLD) begin
                hold_o_ctrl_pipe = 1'b1;
                // Last stall cycle: PC steps at the edge that ends the stall.
                if (cnt_q == '0) begin
                    state_d = CTRL_RUN;
                    pc_d    = pc_q + ADDR_W'(4);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (hold_rise) begin
                hold_o_ctrl_pipe = 1'b1;
                state_d = CTRL_HOLD;
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            hold_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_o_ctrl_ifu = pc_q;
    assign misalign_o    = mis_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scenario bench for pc_ctrl: each task queues per-cycle stimulus with its
// expected outputs and compares them as the cycles play out.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, en_i, jmp, hold;
    logic [31:0] tgt;
    logic [7:0]  pc;
    logic        h, f, m;

    always #5 clk = ~clk;

    pc_ctrl #(.ADDR_W(8), .RESET_PC(8'h00), .HOLD_CYCLES(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .en_i                    (en_i),
        .jump_en_i_exu2ctrl      (jmp),
        .jump_to_addr_i_exu2ctrl (tgt),
        .hold_flag_i_exu2ctrl    (hold),
        .pc_o_ctrl_ifu           (pc),
        .hold_o_ctrl_pipe        (h),
        .flush_o_ctrl_pipe       (f),
        .misalign_o              (m)
    );

    typedef struct {
        logic        rst, en, jmp, hold;
        logic [31:0] tgt;
        logic [7:0]  pc;
        logic        h, f, m, chk;
    } row_t;

    row_t        stim_q[$];
    logic [10:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic void add(logic r, logic e, logic j, logic hf, logic [31:0] t,
                                logic [7:0] p, logic eh, logic ef, logic em, logic c);
        row_t x;
        x.rst = r; x.en = e; x.jmp = j; x.hold = hf; x.tgt = t;
        x.pc = p; x.h = eh; x.f = ef; x.m = em; x.chk = c;
        stim_q.push_back(x);
    endfunction

    task automatic drive(input row_t r);
        rst = r.rst; en_i = r.en; jmp = r.jmp; hold = r.hold; tgt = r.tgt;
        if (r.chk) exp_q.push_back({r.pc, r.h, r.f, r.m});
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h want=00", pc); end
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b want=0", h); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b want=0", f); end
        checks++; if (m !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b want=0", m); end
    endtask

    task automatic test_free_run;
        row_t r; logic [10:0] e;
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 8'(4 * i), 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL free_run row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump;
        row_t r; logic [10:0] e;
        add(0, 1, 1, 0, 32'h40, 8'h10, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0,      8'h40, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h44, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL jump row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold;
        row_t r; logic [10:0] e;
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h04, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 8'h08, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 8'h08, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 8'h08, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 8'h0C, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 8'h10, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h14, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL hold row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_in_hold;
        row_t r; logic [10:0] e;
        add(0, 1, 0, 1, 0,      8'h18, 1, 0, 0, 1);
        add(0, 1, 1, 0, 32'h20, 8'h18, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0,      8'h20, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h24, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL jump_in_hold row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable;
        row_t r; logic [10:0] e;
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h00, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 32'h60, 8'h00, 1, 0, 0, 1);
        add(0, 1, 1, 1, 32'h60, 8'h00, 0, 1, 0, 1);
        add(0, 1, 0, 1, 0,      8'h60, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h64, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL enable row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap;
        row_t r; logic [10:0] e;
        add(0, 1, 1, 0, 32'hFC, 8'h68, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0,      8'hFC, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h04, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL wrap row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misalign;
        row_t r; logic [10:0] e;
        add(0, 1, 1, 0, 32'h42,        8'h08, 0, 1, 0, 1);
        add(0, 1, 1, 0, 32'h80,        8'h40, 0, 1, 1, 1);
        add(0, 1, 1, 0, 32'h1234_5610, 8'h80, 0, 1, 1, 1);
        add(0, 1, 0, 0, 0,             8'h10, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0,             8'h14, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0,             8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,             8'h04, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL misalign row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_priority;
        row_t r; logic [10:0] e;
        add(0, 1, 0, 1, 0,      8'h08, 1, 0, 0, 1);
        add(1, 1, 1, 1, 32'h30, 8'h08, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,      8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,      8'h04, 0, 0, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            r = stim_q.pop_front(); drive(r); #2;
            if (r.chk) begin
                e = exp_q.pop_front(); checks++;
                if ({pc, h, f, m} !== e) begin failures++;
                    $display("FAIL reset_priority row%0d got pc=%h h=%b f=%b m=%b want %h/%b/%b/%b", i, pc, h, f, m, e[10:3], e[2], e[1], e[0]); end
            end
            @(posedge clk); #1;
        end
    endtask

    // flush and hold must never be asserted together
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((h & f) !== 1'b0) begin
                failures++;
                $display("FAIL hold_flush_excl got hold=%b flush=%b want not both 1", h, f);
            end
        end
    end

    initial begin
        rst = 1'b1; en_i = 1'b1; jmp = 1'b0; hold = 1'b0; tgt = '0;
        test_reset();
        test_free_run();
        test_jump();
        test_hold();
        test_jump_in_hold();
        test_enable();
        test_wrap();
        test_misalign();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Pipeline control unit: consumes the execute stage's jump request, jump target and hold flag, and owns the program counter. It drives fetch and the two pipeline registers (if2id, id2exu) with stall and flush commands. It sits between the execute unit and the instruction fetch/ROM address port. It is the receiving end of the execute-to-ctrl interface.

## Interface
Parameters:
- ADDR_W, default 8: PC width in bits; equals $clog2(`ROM_DEPTH`). Byte address.
- RESET_PC, default 0: PC value after reset; must be word aligned.
- HOLD_CYCLES, default 2: stall length in cycles after a hold request, not counting the request cycle. Range 1–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, **synchronous, active-high**.
- en_i  in  1  core run enable; 0 freezes PC, state, counter and the hold-edge register.
- jump_en_i_exu2ctrl  in  1  execute stage requests a redirect this cycle.
- jump_to_addr_i_exu2ctrl  in  32  redirect target (byte address).
- hold_flag_i_exu2ctrl  in  1  execute stage requests a stall.
- pc_o_ctrl_ifu  out  ADDR_W  current fetch address (registered).
- hold_o_ctrl_pipe  out  1  freeze the if2id and id2exu registers this cycle (combinational).
- flush_o_ctrl_pipe  out  1  load NOP into if2id and id2exu at the next edge (combinational).
- misalign_o  out  1  sticky flag: a taken jump had target[1:0] ≠ 0 (registered).

## Operation
- States: RUN and HOLD. Down-counter cnt, width 4. Register hold_q holds the previous cycle's hold_flag_i.
- hold_rise = hold_flag_i & ~hold_q. Only the rising edge starts a stall; a flag held high by a frozen instruction does not restart it.
- Priority order per cycle: rst, then ~en_i, then jump_en_i, then hold_rise, then normal advance.
- rst: pc = RESET_PC, state = RUN, cnt = 0, hold_q = 0, misalign_o = 0.
- en_i = 0:
  - hold_o = 1, flush_o = 0.
  - No register changes, including hold_q.
  - Jump and hold inputs are ignored.
- RUN, jump_en_i = 1:
  - flush_o = 1, hold_o = 0.
  - pc ← {jump_to_addr[ADDR_W-1:2], 2'b00}. Upper target bits are discarded.
  - If target[1:0] ≠ 0, misalign_o ← 1.
- RUN, hold_rise with no jump:
  - hold_o = 1 in the same cycle; pc unchanged.
  - state ← HOLD, cnt ← HOLD_CYCLES − 1.
- RUN, otherwise: pc ← pc + 4, modulo 2^ADDR_W. hold_o = 0, flush_o = 0.
- HOLD:
  - hold_o = 1; pc frozen; hold_flag_i is ignored.
  - cnt decrements each enabled cycle. When cnt = 0 the state goes to RUN.
  - If jump_en_i = 1: behave exactly as RUN with a jump (flush, redirect), state ← RUN, cnt ← 0.
- hold_q ← hold_flag_i on every enabled cycle.
- misalign_o is cleared only by rst.

## Timing
- PC redirect latency is 1 edge: a jump seen in cycle N puts the target on pc_o in cycle N+1.
- Branch penalty is 2 slots: both pipeline registers are loaded with NOP at the same edge.
- A hold request in cycle N holds hold_o high for cycles N through N+HOLD_CYCLES. The PC resumes advancing at the edge ending cycle N+HOLD_CYCLES.
- flush_o and hold_o are never both high.
- Reset asserted mid-HOLD or mid-jump wins at that edge. The cycle after reset is RUN with pc = RESET_PC.
- Wrap-around: pc = 2^ADDR_W − 4 advances to 0 with no flag.

## Structure
- Shared package/defines: state encodings CTRL_RUN and CTRL_HOLD, and the NOP encoding 32'h00000013 used by the pipeline registers.
- Single module; no sub-modules.
- The next-PC mux and the FSM live in one module: one combinational next-state block and one clocked register block.

## Test plan
- Reset then free-run, en_i = 1: pc_o = 0, 4, 8, 12; hold_o = flush_o = 0 throughout.
- Jump at pc = 0x10 to 0x40: flush_o = 1 for exactly that cycle; next pc_o = 0x40, then 0x44.
- hold_flag held high for 5 cycles at pc = 0x08, HOLD_CYCLES = 2:
  - hold_o high for exactly 3 cycles, pc stays 0x08 throughout, then pc advances to 0x0C.
  - No re-stall while the flag stays high.
- Jump during HOLD to 0x20: hold_o drops, flush_o = 1, pc = 0x20 the next cycle, state = RUN.
- Jump to 0x42: pc = 0x40 and misalign_o = 1. misalign_o stays 1 across later jumps and clears only on rst.
- en_i = 0 for 3 cycles mid-HOLD and with jump_en_i = 1: pc, cnt and state are unchanged, hold_o = 1. Once en_i = 1 the pending jump is taken.
